// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-128 block loader.
package aes_pkg;

  localparam int AES_LATENCY_DFLT = 12;
  localparam int KEY_LAT_DFLT     = 10;
  localparam int WORD_W           = 32;
  localparam int BLK_W            = 128;

  typedef enum logic [1:0] {
    NO_KEY,
    SETTLE,
    RUN,
    DRAIN
  } ld_state_e;

endpackage

// File: rtl/aes_word_packer.sv
// Packs four 32-bit words (first word = MSBs) into a 128-bit block.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  input  logic              wvalid,
  output logic [BLK_W-1:0]  blk,
  output logic              done
);

  logic [BLK_W-1:0] shadow;
  logic [1:0]       cnt;
  logic             acc;

  assign acc  = en & wvalid;
  // While accepting, blk already includes the incoming word; otherwise it is the held shadow.
  assign blk  = acc ? {shadow[BLK_W-WORD_W-1:0], word} : shadow;
  assign done = acc & (cnt == 2'd3);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (acc) begin
      shadow <= blk;
      cnt    <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Feeds key and plaintext blocks to the AES-128 pipeline core, draining in-flight
// blocks before any key change and tracking result validity.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int AES_LATENCY = AES_LATENCY_DFLT,
  parameter int KEY_LAT     = KEY_LAT_DFLT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] key_word,
  input  logic              key_wvalid,
  output logic              key_wready,
  input  logic [WORD_W-1:0] din_word,
  input  logic              din_wvalid,
  output logic              din_wready,
  output logic [BLK_W-1:0]  aes_key,
  output logic [BLK_W-1:0]  aes_data,
  output logic              blk_issue,
  output logic              res_valid,
  output logic              busy
);

  localparam int SCW = $clog2(KEY_LAT + 1);

  ld_state_e              state, state_nxt;
  logic [SCW-1:0]         settle_cnt, settle_nxt;
  logic [AES_LATENCY-1:0] vpipe;
  logic [BLK_W-1:0]       key_blk, data_blk;
  logic                   key_done, data_done, key_load, inflight;

  assign key_wready = (state == NO_KEY) || (state == RUN);
  assign din_wready = (state == RUN);
  assign busy       = (state != RUN);
  assign res_valid  = vpipe[AES_LATENCY-1];
  assign inflight   = blk_issue | (|vpipe);

  aes_word_packer u_key_pack (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (key_wready),
    .word   (key_word),
    .wvalid (key_wvalid),
    .blk    (key_blk),
    .done   (key_done)
  );

  aes_word_packer u_data_pack (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (din_wready),
    .word   (din_word),
    .wvalid (din_wvalid),
    .blk    (data_blk),
    .done   (data_done)
  );

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    key_load   = 1'b0;
    unique case (state)
      NO_KEY: if (key_done) begin
        key_load   = 1'b1;
        settle_nxt = '0;
        state_nxt  = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SCW'(KEY_LAT - 1)) state_nxt = RUN;
        else settle_nxt = settle_cnt + SCW'(1);
      end
      // A block completing together with the key still issues under the old key.
      RUN: if (key_done) state_nxt = DRAIN;
      DRAIN: if (!inflight) begin
        key_load   = 1'b1;
        settle_nxt = '0;
        state_nxt  = SETTLE;
      end
      default: state_nxt = NO_KEY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= NO_KEY;
      settle_cnt <= '0;
      aes_key    <= '0;
      aes_data   <= '0;
      blk_issue  <= 1'b0;
      vpipe      <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      if (key_load)  aes_key  <= key_blk;
      if (data_done) aes_data <= data_blk;
      blk_issue  <= data_done;
      vpipe      <= {vpipe[AES_LATENCY-2:0], blk_issue};
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader; models the AES core as a fixed-latency encryptor
// of the key/data it sampled, checked against a scoreboard of expected blocks.
module tb_aes_block_loader;
  import aes_pkg::*;

  localparam int LAT  = 12;
  localparam int KLAT = 10;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [31:0]  key_word = '0, din_word = '0;
  logic         key_wvalid = 1'b0, din_wvalid = 1'b0;
  logic         key_wready, din_wready, blk_issue, res_valid, busy;
  logic [127:0] aes_key, aes_data;

  always #5 CLK = ~CLK;

  aes_block_loader #(.AES_LATENCY(LAT), .KEY_LAT(KLAT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .key_word(key_word), .key_wvalid(key_wvalid), .key_wready(key_wready),
    .din_word(din_word), .din_wvalid(din_wvalid), .din_wready(din_wready),
    .aes_key(aes_key), .aes_data(aes_data),
    .blk_issue(blk_issue), .res_valid(res_valid), .busy(busy)
  );

  typedef struct { logic [127:0] key; logic [127:0] pt; logic [127:0] ct; } blk_t;
  typedef struct { blk_t b; int due; } flight_t;

  blk_t    issue_q[$];
  flight_t flight_q[$];
  int      issue_cyc_q[$];
  int      errors = 0, checks = 0, cyc = 0, last_kchg = 0, last_res = -100;
  logic [127:0] prev_key = '0;
  logic [127:0] hk[16], hd[16];
  logic [7:0]   sbox[256];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] PT_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = '0;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [127:0] s, t;
    logic [7:0]   rc, a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] tmp;
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[127-8*(row+4*c) -: 8] = sbox[s[127-8*(row+4*((c+row)%4)) -: 8]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          t[127-32*c -: 32] = {gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                               gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)};
        end
      end
      s = t ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // ---------------- monitor / stand-in core ----------------
  always @(negedge CLK) begin
    blk_t         e;
    flight_t      f;
    logic [127:0] out;
    int           idx;
    cyc++;
    if (aes_key !== prev_key) last_kchg = cyc;
    prev_key = aes_key;
    hk[cyc % 16] = aes_key;
    hd[cyc % 16] = aes_data;
    if (blk_issue === 1'b1) begin
      checks++;
      if (issue_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: blk_issue=1 at cycle %0d, required 0", cyc);
      end else begin
        e = issue_q.pop_front();
        if (aes_data !== e.pt || aes_key !== e.key) begin
          errors++;
          $display("FAIL issue_block: data=%h key=%h, required data=%h key=%h", aes_data, aes_key, e.pt, e.key);
        end
        f.b = e; f.due = cyc + LAT;
        flight_q.push_back(f);
        issue_cyc_q.push_back(cyc);
      end
    end
    if (res_valid === 1'b1) begin
      last_res = cyc;
      checks++;
      if (flight_q.size() == 0 || cyc < LAT) begin
        errors++;
        $display("FAIL res_unexpected: res_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        f = flight_q.pop_front();
        idx = (cyc - LAT) % 16;
        out = aes_encrypt(hk[idx], hd[idx]);
        if (cyc != f.due) begin
          errors++;
          $display("FAIL res_timing: res_valid at cycle %0d, required %0d", cyc, f.due);
        end
        checks++;
        if (out !== f.b.ct) begin
          errors++;
          $display("FAIL ciphertext: got %h, required %h", out, f.b.ct);
        end
        checks++;
        if (last_kchg > cyc - LAT) begin
          errors++;
          $display("FAIL key_stable: key changed at cycle %0d, required no change after %0d", last_kchg, cyc - LAT);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic put_key(input logic [31:0] w);
    int n = 0;
    key_word = w; key_wvalid = 1'b1;
    while (key_wready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL key_wready_timeout: waited %0d cycles, required < 200", n);
    end
    tick();
    key_wvalid = 1'b0;
  endtask

  task automatic put_data(input logic [31:0] w);
    int n = 0;
    din_word = w; din_wvalid = 1'b1;
    while (din_wready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL din_wready_timeout: waited %0d cycles, required < 200", n);
    end
    tick();
    din_wvalid = 1'b0;
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) put_key(k[127-32*i -: 32]);
  endtask

  task automatic queue_block(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] ct);
    blk_t e;
    e.key = k; e.pt = pt; e.ct = ct;
    issue_q.push_back(e);
  endtask

  task automatic send_data(input logic [127:0] pt);
    for (int i = 0; i < 4; i++) put_data(pt[127-32*i -: 32]);
  endtask

  task automatic wait_settle(input string tag);
    int n = 0;
    while (din_wready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != KLAT) begin
      errors++;
      $display("FAIL settle_%s: din_wready rose after %0d cycles, required %0d", tag, n, KLAT);
    end
  endtask

  task automatic wait_key_change(input string tag, input logic [127:0] oldk, input logic [127:0] newk);
    int n = 0;
    bit ok = 1'b1;
    while (aes_key === oldk && n < 200) begin
      if (din_wready !== 1'b0 || key_wready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      tick(); n++;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL drain_ready_%s: ready/busy wrong during drain, required wready=0 busy=1", tag); end
    checks++;
    if (aes_key !== newk) begin errors++; $display("FAIL key_update_%s: got %h, required %h", tag, aes_key, newk); end
    checks++;
    if (cyc + 1 != last_res + 2) begin
      errors++;
      $display("FAIL key_update_cycle_%s: key changed in cycle %0d, required %0d", tag, cyc + 1, last_res + 2);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((flight_q.size() != 0 || issue_q.size() != 0) && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout_%s: %0d blocks outstanding, required 0", tag, flight_q.size() + issue_q.size());
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({key_wready, din_wready, busy, res_valid, blk_issue} !== 5'b10100) begin
      errors++;
      $display("FAIL %s_flags: kr/dr/busy/rv/issue=%b, required 10100", tag, {key_wready, din_wready, busy, res_valid, blk_issue});
    end
    checks++;
    if (aes_key !== '0) begin errors++; $display("FAIL %s_key: got %h, required 0", tag, aes_key); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    check_idle("reset");
    checks++;
    if (aes_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", aes_data); end
  endtask

  task automatic test_fips();
    send_key(K1);
    wait_settle("fips");
    queue_block(K1, PT_FIPS, CT_FIPS);
    send_data(PT_FIPS);
    checks++;
    if (blk_issue !== 1'b1 || aes_data !== PT_FIPS) begin
      errors++;
      $display("FAIL fips_issue: issue=%b data=%h, required 1 %h", blk_issue, aes_data, PT_FIPS);
    end
    tick();
    checks++;
    if (blk_issue !== 1'b0) begin errors++; $display("FAIL fips_pulse: blk_issue=%b, required 0", blk_issue); end
    wait_drain("fips");
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts[3];
    issue_cyc_q.delete();
    for (int b = 0; b < 3; b++) begin
      pts[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      queue_block(K1, pts[b], aes_encrypt(K1, pts[b]));
    end
    for (int b = 0; b < 3; b++) send_data(pts[b]);
    wait_drain("b2b");
    checks++;
    if (issue_cyc_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: %0d issues, required 3", issue_cyc_q.size());
    end else begin
      checks++;
      if (issue_cyc_q[1] - issue_cyc_q[0] != 4 || issue_cyc_q[2] - issue_cyc_q[1] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: gaps %0d %0d, required 4 4", issue_cyc_q[1] - issue_cyc_q[0], issue_cyc_q[2] - issue_cyc_q[1]);
      end
    end
  endtask

  task automatic test_key_change();
    logic [127:0] p0, p1, p2;
    p0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    queue_block(K1, p0, aes_encrypt(K1, p0));
    queue_block(K1, p1, aes_encrypt(K1, p1));
    send_data(p0);
    send_data(p1);
    send_key(K2);
    wait_key_change("kchg", K1, K2);
    wait_settle("kchg");
    queue_block(K2, p2, aes_encrypt(K2, p2));
    send_data(p2);
    wait_drain("kchg");
  endtask

  task automatic test_collision();
    logic [127:0] p, q;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    q = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 3; i++) put_key(K3[127-32*i -: 32]);
    for (int i = 0; i < 3; i++) put_data(p[127-32*i -: 32]);
    queue_block(K2, p, aes_encrypt(K2, p));
    key_word = K3[31:0]; key_wvalid = 1'b1;
    din_word = p[31:0];  din_wvalid = 1'b1;
    checks++;
    if (key_wready !== 1'b1 || din_wready !== 1'b1) begin
      errors++;
      $display("FAIL collide_ready: kr=%b dr=%b, required 1 1", key_wready, din_wready);
    end
    tick();
    key_wvalid = 1'b0; din_wvalid = 1'b0;
    wait_key_change("collide", K2, K3);
    wait_settle("collide");
    queue_block(K3, q, aes_encrypt(K3, q));
    send_data(q);
    wait_drain("collide");
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] p0, p1, p2;
    int rv = 0;
    p0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    queue_block(K3, p0, aes_encrypt(K3, p0));
    queue_block(K3, p1, aes_encrypt(K3, p1));
    send_data(p0);
    send_data(p1);
    put_data(32'h11111111);
    put_data(32'h22222222);
    send_key(K1);
    tick();
    RST_N = 1'b0;
    flight_q.delete();
    tick(); tick();
    RST_N = 1'b1;
    check_idle("rst_drain");
    for (int i = 0; i < 25; i++) begin
      if (res_valid === 1'b1) rv++;
      tick();
    end
    checks++;
    if (rv != 0) begin errors++; $display("FAIL rst_drain_res: %0d res_valid pulses, required 0", rv); end
    send_key(K1);
    wait_settle("rst_drain");
    queue_block(K1, p2, aes_encrypt(K1, p2));
    send_data(p2);
    wait_drain("rst_drain");
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_back_to_back();
    test_key_change();
    test_collision();
    test_reset_mid_drain();
    repeat (3) tick();
    checks++;
    if (issue_q.size() != 0 || flight_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d issue, %0d flight outstanding, required 0 0", issue_q.size(), flight_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the AES-128 pipeline core.
- Collects a 128-bit key and 128-bit plaintext blocks from 32-bit valid/ready word streams, and drives the core's key_in/data_in inputs.
- Emits an issue pulse per block, and a result-valid flag aligned to the core's data_out.
- Drains in-flight blocks before any key change, because the core's expanded round keys are per-stage and would corrupt blocks still in the pipe.

Parameters:
- AES_LATENCY, 12, cycles from the core sampling data_in to data_out holding that block's ciphertext.
- KEY_LAT, 10, settle cycles after key_in changes before expanded keys are valid in every stage.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- key_word  in  32  key word; first word = bits [127:96].
- key_wvalid  in  1  key word valid.
- key_wready  out  1  key word accepted when valid&ready.
- din_word  in  32  plaintext word; first word = bits [127:96].
- din_wvalid  in  1  plaintext word valid.
- din_wready  out  1  plaintext word accepted when valid&ready.
- aes_key  out  128  drives core key_in.
- aes_data  out  128  drives core data_in.
- blk_issue  out  1  one-cycle pulse; aes_data holds a new block this cycle.
- res_valid  out  1  core data_out holds a valid ciphertext this cycle.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Interface: one clock CLK. Reset RST_N is synchronous and active-low.
- Reset: state=NO_KEY. aes_key, aes_data, blk_issue, res_valid, word counters, shadow key and valid pipe all 0.
- Reset mid-operation discards partial words and in-flight tracking. No res_valid is raised for blocks already inside the core.
- States: NO_KEY, SETTLE, RUN, DRAIN.
- key_wready = (NO_KEY or RUN).
- din_wready = RUN.
- Key packing: 2-bit counter; each accepted word shifts into the shadow key.
- On the 4th key word:
  - from NO_KEY: aes_key<=shadow at that edge, go to SETTLE.
  - from RUN: go to DRAIN.
- DRAIN: wait until inflight==0, where inflight = blk_issue OR any bit of vpipe. On that edge aes_key<=shadow, go to SETTLE.
- SETTLE: count KEY_LAT cycles with din_wready=0, then go to RUN.
- Data packing: 2-bit counter. On the 4th accepted word, at that edge aes_data<=assembled block and blk_issue<=1 for exactly one cycle.
- aes_data holds its value otherwise; between issues it is don't-care to the core.
- Throughput: one word per cycle sustained, so at most one block every 4 cycles.
- Partial data words survive DRAIN/SETTLE. Packing resumes in RUN with no loss.
- Valid pipe: vpipe[AES_LATENCY-1:0] shifts in blk_issue every cycle, and res_valid = vpipe[AES_LATENCY-1]. A blk_issue in cycle t gives res_valid in cycle t+AES_LATENCY.
- Simultaneous 4th key word and 4th data word in RUN: the block issues under the old key. DRAIN then waits for its res_valid before the key update.
- Key words are never accepted in DRAIN or SETTLE (ready=0). A partial key received in RUN is kept until completion.

Decomposition:
- Package aes_pkg holds:
  - AES_LATENCY and KEY_LAT defaults.
  - WORD_W=32 and BLK_W=128.
  - State enum {NO_KEY, SETTLE, RUN, DRAIN}.
- Sub-module aes_word_packer: 32-to-128 shift register, 2-bit counter, done pulse. Instantiated twice, for key and data.
- Top holds the FSM, settle counter and valid pipe.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles, release. Expect key_wready=1, din_wready=0, busy=1, aes_key=0, res_valid=0.
- FIPS-197 vector:
  - Load key 2b7e1516 28aed2a6 abf71588 09cf4f3c. din_wready must rise exactly 10 cycles after the 4th key word edge.
  - Send 3243f6a8 885a308d 313198a2 e0370734. Expect a single blk_issue with aes_data=3243f6a8885a308d313198a2e0370734.
  - 12 cycles later: res_valid=1 and core data_out=3925841d02dc09fbdc118597196a0b32.
- Back-to-back: 3 blocks streamed one word per cycle. Expect blk_issue every 4 cycles and 3 res_valid pulses with 4-cycle spacing, each matching the reference model.
- Key change in flight: 2 blocks issued, then 4 key words sent. Expect:
  - din_wready=0 and aes_key unchanged until the cycle after the last res_valid.
  - SETTLE of 10 cycles, then a block encrypts correctly under the new key.
- Collision: 4th key word and 4th data word in the same cycle. Expect that block's res_valid and ciphertext under the old key before aes_key changes.
- Reset mid-DRAIN: assert RST_N=0 with 2 blocks in flight and 2 data words partially packed. Expect NO_KEY, no res_valid ever, and data counter 0 on the next block.
